systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencer for one matrix-multiply pass through the N×N systolic array and its skew delay lines. On `start` it clears the PE accumulators and streams K operand-word addresses to the operand memories. It then feeds zeros until the skewed data has fully propagated, and reads the N result rows out in order. It sits between the host command interface and the array/skew-buffer datapath.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns); N ≥ 2
- `K_MAX`, 16: maximum inner dimension per pass
- `ADDR_WIDTH`, 8: operand memory address width
- `KW`, $clog2(K_MAX+1): width of `k_len`

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `clear`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a pass; sampled only in IDLE
- `k_len`  in  KW  inner dimension; sampled with `start`
- `base_addr`  in  ADDR_WIDTH  first operand address; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `acc_clear`  out  1  one-cycle accumulator clear to all PEs
- `rd_en`  out  1  operand memory read strobe
- `rd_addr`  out  ADDR_WIDTH  operand read address
- `feed_valid`  out  1  skew-line inputs carry meaningful words (data or zero)
- `feed_zero`  out  1  force skew-line inputs to zero (flush)
- `out_valid`  out  1  result row on array output this cycle
- `out_row`  out  $clog2(N)  index of result row being read
- `done`  out  1  one-cycle pulse at end of pass

## Operation
- States: IDLE → CLR → FEED → FLUSH → DRAIN → DONE → IDLE.
- IDLE:
  - `start`=1 latches `k_len` and `base_addr`, then goes to CLR.
  - `k_len` > K_MAX saturates to K_MAX.
- CLR: 1 cycle, `acc_clear`=1. Next state is FEED if latched k>0, else DRAIN.
- FEED: k cycles.
  - `rd_en`=`feed_valid`=1.
  - `rd_addr` = base + i for i = 0..k−1, modulo 2^ADDR_WIDTH; wraps past all-ones to 0.
- FLUSH: 2N−2 cycles, `feed_valid`=`feed_zero`=1, `rd_en`=0.
- DRAIN: N cycles, `out_valid`=1, `out_row` = 0..N−1 ascending.
- DONE: 1 cycle, `done`=1, then IDLE.
- Rules:
  - Outputs are registered and decoded from state and counter only.
  - `start` outside IDLE is ignored, including in the DONE cycle.
  - `k_len`/`base_addr` changes after acceptance have no effect.
- Reset (`clear`=1, at any time, including mid-pass):
  - State IDLE immediately; all outputs 0; `rd_addr`=0; counters 0.
  - The first `start` is accepted on the first rising edge after `clear` falls.

## Timing
- `start` accepted at edge 0: CLR is cycle 1, FEED cycles 2..k+1, FLUSH k+2..k+2N−1, DRAIN k+2N..k+3N−1, `done` at cycle k+3N.
- `busy` rises the cycle after acceptance and falls the cycle after `done`.
- Total pass length is k+3N+1 cycles, including the IDLE acceptance cycle.
- k=0: CLR at cycle 1, DRAIN at cycles 2..N+1, `done` at N+2. No FEED/FLUSH, and `rd_en` is never asserted.
- Back-to-back passes: earliest next acceptance is the cycle after `done`.

## Configuration
- `SYSTOLIC_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge and asserts `acc_clear` for that one cycle.
  - No `done` pulse is produced.
  - `abort` in IDLE is ignored, and it takes priority over `start`.
- Undefined: port absent; passes always run to completion.

## Structure
- Package `systolic_pkg`:
  - state enum `seq_state_t` (IDLE, CLR, FEED, FLUSH, DRAIN, DONE)
  - function for flush length 2N−2
  - width helper for `out_row`/`k_len`
- Sub-module `phase_counter`: loadable down-counter with a terminal-count flag, shared across the FEED/FLUSH/DRAIN phase lengths. The FSM loads it on each state entry.
- The address counter is a separate ADDR_WIDTH incrementer in the top.

## Test plan
- N=4, k=3, base=0x10, `start` at cycle 0:
  - `acc_clear` at cycle 1
  - `rd_addr` 0x10,0x11,0x12 at cycles 2–4
  - `feed_zero` at cycles 5–10
  - `out_row` 0..3 at cycles 11–14
  - `done` at cycle 15
- base=0xFE, k=4: `rd_addr` sequence 0xFE,0xFF,0x00,0x01.
- k_len=0: no `rd_en`; DRAIN at cycles 2–5; `done` at cycle 6. k_len=31 with K_MAX=16: exactly 16 reads.
- `start` held high continuously: passes accepted only in IDLE, with `done` pulses exactly 3N+k+1 cycles apart.
- `clear` asserted in FLUSH: all outputs 0 asynchronously; a new `start` after release runs a full correct pass.
- With `SYSTOLIC_SEQ_ABORT_EN`, `abort` in FEED: next cycle `busy`=0 and `acc_clear`=1; no `done` pulse.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array pass sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    // Cycles of zero feed needed for skewed data to reach the far corner.
    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n - 2;
    endfunction

    // Bits needed to index 0..count-1 (never less than one).
    function automatic int unsigned idx_width(input int unsigned count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host command / datapath control bundle of the systolic pass sequencer.
// SYSTOLIC_SEQ_ABORT_EN adds the abort request.
interface systolic_seq_ctrl_if
    import systolic_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned KW         = idx_width(K_MAX + 1)
) ();

    localparam int unsigned RW = idx_width(N);

    logic                  start;
    logic [KW-1:0]         k_len;
    logic [ADDR_WIDTH-1:0] base_addr;
`ifdef SYSTOLIC_SEQ_ABORT_EN
    logic                  abort;
`endif
    logic                  busy;
    logic                  acc_clear;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  feed_valid;
    logic                  feed_zero;
    logic                  out_valid;
    logic [RW-1:0]         out_row;
    logic                  done;

`ifdef SYSTOLIC_SEQ_ABORT_EN
    modport master (output start, k_len, base_addr, abort,
                    input  busy, acc_clear, rd_en, rd_addr, feed_valid,
                           feed_zero, out_valid, out_row, done);
    modport slave  (input  start, k_len, base_addr, abort,
                    output busy, acc_clear, rd_en, rd_addr, feed_valid,
                           feed_zero, out_valid, out_row, done);
`else
    modport master (output start, k_len, base_addr,
                    input  busy, acc_clear, rd_en, rd_addr, feed_valid,
                           feed_zero, out_valid, out_row, done);
    modport slave  (input  start, k_len, base_addr,
                    output busy, acc_clear, rd_en, rd_addr, feed_valid,
                           feed_zero, out_valid, out_row, done);
`endif

endinterface

// File: rtl/systolic_seq_ctrl_phase_counter.sv
// Loadable down-counter timing the FEED/FLUSH/DRAIN phases; holds at zero.
module phase_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count_nxt_c,
    output logic         tc_c
);

    logic [W-1:0] count;

    always_comb begin
        count_nxt_c = count;
        if (load) begin
            count_nxt_c = load_val;
        end else if (count != '0) begin
            count_nxt_c = count - W'(1);
        end
    end

    assign tc_c = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt_c;
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one matrix-multiply pass: clear, operand feed, skew flush, row drain.
// SYSTOLIC_SEQ_ABORT_EN enables mid-pass abort back to IDLE.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned KW         = idx_width(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                clear,
    systolic_seq_ctrl_if.slave  bus
);

    localparam int unsigned RW = idx_width(N);
    localparam int unsigned FL = flush_len(N);
    localparam int unsigned CW = idx_width(max3(K_MAX, FL, N));

    seq_state_t            state, state_nxt;
    logic [KW-1:0]         k_lat, k_nxt;
    logic [ADDR_WIDTH-1:0] base_lat, base_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  cnt_load_c, cnt_tc_c, abort_c;
    logic [CW-1:0]         cnt_load_val_c, cnt_nxt_c;

    logic busy_q, acc_clear_q, rd_en_q, feed_valid_q, feed_zero_q, out_valid_q, done_q;
    logic busy_nxt, acc_clear_nxt, rd_en_nxt, feed_valid_nxt, feed_zero_nxt;
    logic out_valid_nxt, done_nxt;
    logic [RW-1:0] out_row_q, out_row_nxt;

`ifdef SYSTOLIC_SEQ_ABORT_EN
    assign abort_c = bus.abort && (state != IDLE);
`else
    assign abort_c = 1'b0;
`endif

    phase_counter #(.W(CW)) u_phase_cnt (
        .clk         (clk),
        .rst         (clear),
        .load        (cnt_load_c),
        .load_val    (cnt_load_val_c),
        .count_nxt_c (cnt_nxt_c),
        .tc_c        (cnt_tc_c)
    );

    // Next state; the phase counter is reloaded on every timed-phase entry.
    always_comb begin
        state_nxt      = state;
        k_nxt          = k_lat;
        base_nxt       = base_lat;
        cnt_load_c     = 1'b0;
        cnt_load_val_c = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CLR;
                    k_nxt     = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
                    base_nxt  = bus.base_addr;
                end
            end
            CLR: begin
                cnt_load_c = 1'b1;
                if (k_lat != '0) begin
                    state_nxt      = FEED;
                    cnt_load_val_c = CW'(k_lat - KW'(1));
                end else begin
                    state_nxt      = DRAIN;
                    cnt_load_val_c = CW'(N - 1);
                end
            end
            FEED: begin
                if (cnt_tc_c) begin
                    state_nxt      = FLUSH;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = CW'(FL - 1);
                end
            end
            FLUSH: begin
                if (cnt_tc_c) begin
                    state_nxt      = DRAIN;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = CW'(N - 1);
                end
            end
            DRAIN: begin
                if (cnt_tc_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_c) begin
            state_nxt = IDLE;
        end
    end

    // Output decode from the upcoming state/count so registered outputs align with state.
    always_comb begin
        addr_nxt = '0;
        if (state_nxt == FEED) begin
            addr_nxt = (state == FEED) ? addr_q + ADDR_WIDTH'(1) : base_lat;
        end
        busy_nxt       = (state_nxt != IDLE);
        acc_clear_nxt  = (state_nxt == CLR) || abort_c;
        rd_en_nxt      = (state_nxt == FEED);
        feed_valid_nxt = (state_nxt == FEED) || (state_nxt == FLUSH);
        feed_zero_nxt  = (state_nxt == FLUSH);
        out_valid_nxt  = (state_nxt == DRAIN);
        out_row_nxt    = (state_nxt == DRAIN) ? RW'(N - 1) - RW'(cnt_nxt_c) : '0;
        done_nxt       = (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            k_lat        <= '0;
            base_lat     <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            acc_clear_q  <= 1'b0;
            rd_en_q      <= 1'b0;
            feed_valid_q <= 1'b0;
            feed_zero_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            k_lat        <= k_nxt;
            base_lat     <= base_nxt;
            addr_q       <= addr_nxt;
            busy_q       <= busy_nxt;
            acc_clear_q  <= acc_clear_nxt;
            rd_en_q      <= rd_en_nxt;
            feed_valid_q <= feed_valid_nxt;
            feed_zero_q  <= feed_zero_nxt;
            out_valid_q  <= out_valid_nxt;
            out_row_q    <= out_row_nxt;
            done_q       <= done_nxt;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.acc_clear  = acc_clear_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = addr_q;
    assign bus.feed_valid = feed_valid_q;
    assign bus.feed_zero  = feed_zero_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_row    = out_row_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl against a cycle-table model of one pass.
module tb_systolic_seq_ctrl;

    localparam int N    = 4;
    localparam int KMAX = 16;
    localparam int AW   = 8;

    typedef struct packed {
        logic       busy;
        logic       acc_clear;
        logic       rd_en;
        logic [7:0] rd_addr;
        logic       feed_valid;
        logic       feed_zero;
        logic       out_valid;
        logic [1:0] out_row;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.N(N), .K_MAX(KMAX), .ADDR_WIDTH(AW)) bus ();

    systolic_seq_ctrl #(.N(N), .K_MAX(KMAX), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    // Expected outputs c cycles after the accepting edge, straight from the pass timeline.
    function automatic obs_t model(input int k, input int base, input int c);
        obs_t e;
        int   kk;
        int   d0;
        e  = '0;
        kk = (k > KMAX) ? KMAX : k;
        d0 = (kk > 0) ? kk + 2 * N : 2;
        if (c >= 1 && c <= d0 + N) e.busy = 1'b1;
        if (c == 1) begin
            e.acc_clear = 1'b1;
        end else if (kk > 0 && c >= 2 && c <= kk + 1) begin
            e.rd_en      = 1'b1;
            e.feed_valid = 1'b1;
            e.rd_addr    = 8'((base + c - 2) % 256);
        end else if (kk > 0 && c >= kk + 2 && c <= kk + 2 * N - 1) begin
            e.feed_valid = 1'b1;
            e.feed_zero  = 1'b1;
        end else if (c >= d0 && c < d0 + N) begin
            e.out_valid = 1'b1;
            e.out_row   = 2'(c - d0);
        end else if (c == d0 + N) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t raw();
        obs_t a;
        a.busy       = bus.busy;
        a.acc_clear  = bus.acc_clear;
        a.rd_en      = bus.rd_en;
        a.rd_addr    = bus.rd_addr;
        a.feed_valid = bus.feed_valid;
        a.feed_zero  = bus.feed_zero;
        a.out_valid  = bus.out_valid;
        a.out_row    = bus.out_row;
        a.done       = bus.done;
        return a;
    endfunction

    // Address and row index only carry meaning while their strobes are expected.
    function automatic obs_t sample(input obs_t e);
        obs_t a;
        a = raw();
        if (!e.rd_en)     a.rd_addr = '0;
        if (!e.out_valid) a.out_row = '0;
        return a;
    endfunction

    // One full pass from an IDLE cycle (posedge+1) back to IDLE; noisy drives junk while busy.
    task automatic run_pass(input int k, input int base, input bit noisy);
        int   kk;
        int   len;
        obs_t e;
        obs_t a;
        kk  = (k > KMAX) ? KMAX : k;
        len = ((kk > 0) ? kk + 2 * N : 2) + N + 1;
        bus.start     = 1'b1;
        bus.k_len     = 5'(k);
        bus.base_addr = 8'(base);
        @(posedge clk); #1;
        for (int c = 1; c <= len; c++) begin
            e = model(k, base, c);
            a = sample(e);
            checks++;
            if (a !== e)
                $display("FAIL pass k=%0d base=%0h cycle=%0d got=%h exp=%h", k, base, c, a, e);
            else
                passed++;
            if (c < len && noisy) begin
                bus.start     = 1'($urandom);
                bus.k_len     = 5'($urandom);
                bus.base_addr = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (c < len) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        clear         = 1'b1;
        bus.start     = 1'b1;
        bus.k_len     = 5'd3;
        bus.base_addr = 8'h55;
`ifdef SYSTOLIC_SEQ_ABORT_EN
        bus.abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (raw() !== obs_t'(0)) $display("FAIL reset outputs got=%h exp=0", raw());
        else passed++;
        clear     = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_directed();
        run_pass(3, 'h10, 1'b0);
        run_pass(4, 'hFE, 1'b1);
        run_pass(0, 'h33, 1'b1);
        run_pass(31, 'h80, 1'b1);
        run_pass(16, 'hF8, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_pass(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int cyc;
        int t[$];
        k             = 2;
        bus.start     = 1'b1;
        bus.k_len     = 5'(k);
        bus.base_addr = 8'($urandom);
        cyc           = 0;
        for (int i = 0; i < 100 && t.size() < 3; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) t.push_back(cyc);
        end
        bus.start = 1'b0;
        checks++;
        if (t.size() != 3) begin
            $display("FAIL b2b done count got=%0d exp=3", t.size());
        end else begin
            passed++;
            checks++;
            if (t[0] != k + 3 * N) $display("FAIL b2b first done got=%0d exp=%0d", t[0], k + 3 * N);
            else passed++;
            for (int j = 1; j < 3; j++) begin
                checks++;
                if (t[j] - t[j-1] != 3 * N + k + 1)
                    $display("FAIL b2b spacing got=%0d exp=%0d", t[j] - t[j-1], 3 * N + k + 1);
                else
                    passed++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL b2b idle busy got=%b exp=0", bus.busy);
        else passed++;
    endtask

    task automatic test_clear_midpass();
        int   k;
        int   base;
        obs_t e;
        obs_t a;
        k             = 5;
        base          = int'($urandom_range(0, 255));
        bus.start     = 1'b1;
        bus.k_len     = 5'(k);
        bus.base_addr = 8'(base);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        e = model(k, base, 9);
        a = sample(e);
        checks++;
        if (a !== e) $display("FAIL clear pre-flush got=%h exp=%h", a, e);
        else passed++;
        #2 clear = 1'b1;
        #1;
        checks++;
        if (raw() !== obs_t'(0)) $display("FAIL clear async outputs got=%h exp=0", raw());
        else passed++;
        @(posedge clk);
        @(posedge clk); #1;
        clear = 1'b0;
        run_pass(int'($urandom_range(0, 20)), int'($urandom_range(0, 255)), 1'b1);
    endtask

`ifdef SYSTOLIC_SEQ_ABORT_EN
    task automatic test_abort();
        int  seen_done;
        int  seen_busy;
        bus.start     = 1'b1;
        bus.k_len     = 5'd6;
        bus.base_addr = 8'h40;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.acc_clear !== 1'b1)
            $display("FAIL abort next busy=%b acc_clear=%b exp busy=0 acc_clear=1", bus.busy, bus.acc_clear);
        else
            passed++;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 3 * N + 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done++;
            if (bus.busy) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0)
            $display("FAIL abort aftermath done=%0d busy=%0d exp 0 0", seen_done, seen_busy);
        else
            passed++;
        run_pass(3, 'h10, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clear_midpass();
`ifdef SYSTOLIC_SEQ_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
